// File: rtl/sfifo_pkg.sv
// -----------------------------------------------------------------------------
// sfifo_pkg
// Shared constants for the synchronous FIFO and its write-side arbiter.
//   ST_IDLE / ST_BURST : write arbiter FSM state encoding
//   SFIFO_DW           : default data width of the FIFO write port
//   SFIFO_DEPTH        : FIFO depth in words
//   BURST_CW           : width of the per-grant burst counter (MAX_BURST <= 15)
// -----------------------------------------------------------------------------
package sfifo_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int SFIFO_DW    = 8;
    localparam int SFIFO_DEPTH = 8;
    localparam int BURST_CW    = 4;

endpackage : sfifo_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting one position above
// the previous winner and wrapping modulo NREQ; the first set bit wins.
//   req        in   NREQ  request vector
//   last       in   IW    index of the previous winner
//   winner_oh  out  NREQ  one-hot winner (0 when req == 0)
//   winner_idx out  IW    binary index of the winner (0 when req == 0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner_oh,
    output logic [IW-1:0]   winner_idx
);

    // One extra bit so last + offset cannot overflow before the wrap.
    logic [IW:0] pos;
    logic        found;

    // NOTE: every variable gets a default before the loop; without it the
    // no-request path would leave outputs unassigned and infer a latch.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        pos        = '0;
        for (int off = 1; off <= NREQ; off++) begin
            pos = {1'b0, last} + (IW+1)'(off);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!found && req[pos[IW-1:0]]) begin
                found                 = 1'b1;
                winner_idx            = pos[IW-1:0];
                winner_oh[pos[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/sfifo.sv
// -----------------------------------------------------------------------------
// sfifo
// Synchronous single-clock FIFO with show-ahead read data.
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-high reset (pointers and count)
//   write_e  in   1   push data_in (ignored while full)
//   read_e   in   1   pop head (ignored while empty)
//   data_in  in   DW  write data
//   data_out out  DW  current head of the FIFO (valid while !empty)
//   full     out  1   DEPTH words stored
//   empty    out  1   no words stored
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sfifo
    import sfifo_pkg::*;
#(
    parameter int DW    = SFIFO_DW,
    parameter int DEPTH = SFIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write_e,
    input  logic          read_e,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = write_e & ~full;
    assign do_rd = read_e & ~empty;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; contents are only observable
    // after a write, and a reset branch would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= data_in;
    end

    assign data_out = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule : sfifo

// File: rtl/sfifo_wr_arb.sv
// -----------------------------------------------------------------------------
// sfifo_wr_arb
// Round-robin write arbiter placing NREQ producers in front of one sfifo write
// port. A winner owns the port for up to MAX_BURST words, then the FSM spends
// one IDLE cycle re-arbitrating before the next grant.
//   clk          in   1        rising-edge clock shared with sfifo
//   reset        in   1        asynchronous, active-high reset
//   req          in   NREQ     producer requests (held until ack)
//   din          in   NREQ*DW  producer data, slice i = din[i*DW +: DW]
//   fifo_full    in   1        sfifo full flag
//   grant        out  NREQ     registered one-hot owner; 0 when idle
//   ack          out  NREQ     one-hot pulse: owner's word written this cycle
//   fifo_write_e out  1        sfifo write_e
//   fifo_data_in out  DW       sfifo data_in (0 when not writing)
//   busy         out  1        high while a burst is in progress
// -----------------------------------------------------------------------------
module sfifo_wr_arb
    import sfifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = SFIFO_DW,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    input  logic             fifo_full,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  ack,
    output logic             fifo_write_e,
    output logic [DW-1:0]    fifo_data_in,
    output logic             busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [0:0]          state;
    // last doubles as the owner index while in BURST: it is loaded with the
    // winner together with grant and only changes at the next arbitration.
    logic [IW-1:0]       last;
    logic [BURST_CW-1:0] burst_cnt;

    logic [DW-1:0]       din_arr [NREQ];
    logic [NREQ-1:0]     pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                owner_req;
    logic                wr;
    logic                last_word;
    logic                rel;

    for (genvar i = 0; i < NREQ; i++) begin : g_din
        assign din_arr[i] = din[i*DW +: DW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req        (req),
        .last       (last),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx)
    );

    assign busy      = (state == ST_BURST);
    assign owner_req = req[last];
    assign wr        = busy & owner_req & ~fifo_full;
    assign last_word = (burst_cnt == BURST_CW'(MAX_BURST - 1));
    // A full FIFO alone never releases: the owner keeps the port and stalls.
    assign rel       = ~owner_req | (wr & last_word);

    assign fifo_write_e = wr;
    assign fifo_data_in = wr ? din_arr[last] : '0;
    assign ack          = wr ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            last      <= IW'(NREQ - 1);
            burst_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (|req) begin
                state     <= ST_BURST;
                grant     <= pick_oh;
                last      <= pick_idx;
                burst_cnt <= '0;
            end
        end else begin
            if (wr) burst_cnt <= burst_cnt + 1'b1;
            if (rel) begin
                state <= ST_IDLE;
                grant <= '0;
            end
        end
    end

endmodule : sfifo_wr_arb

// File: tb/tb_sfifo_wr_arb.sv
`timescale 1ns/100ps
module tb_sfifo_wr_arb;
    import sfifo_pkg::*;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 8;

    logic                 clk    = 1'b0;
    logic                 reset  = 1'b1;
    logic [NREQ-1:0]      req    = 4'b1111;
    logic [NREQ*DW-1:0]   din    = '0;
    logic                 rd_en  = 1'b0;
    logic                 fifo_full;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      ack;
    logic                 fifo_write_e;
    logic [DW-1:0]        fifo_data_in;
    logic                 busy;
    logic [DW-1:0]        fifo_dout;
    logic                 fifo_empty;

    sfifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .din          (din),
        .fifo_full    (fifo_full),
        .grant        (grant),
        .ack          (ack),
        .fifo_write_e (fifo_write_e),
        .fifo_data_in (fifo_data_in),
        .busy         (busy)
    );

    sfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .write_e  (fifo_write_e),
        .read_e   (rd_en),
        .data_in  (fifo_data_in),
        .data_out (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of the arbiter plus the FIFO contents it should hold.
    logic            m_busy;
    logic [1:0]      m_last;
    int              m_cnt;
    logic [DW-1:0]   sb [$];
    int              ack_cnt [NREQ];
    logic [NREQ-1:0] grant_log [$];
    logic [DW-1:0]   rd_log [$];
    logic [NREQ-1:0] prev_grant;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_last     = 2'(NREQ - 1);
        m_cnt      = 0;
        prev_grant = '0;
        sb.delete();
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        grant_log.delete();
        rd_log.delete();
    endtask

    // Runs at each falling edge: checks the combinational outputs for the
    // current state/inputs, then advances the model across the next rising edge.
    task automatic model_step();
        logic            ef;
        logic            ew;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ea;
        logic [DW-1:0]   ed;
        int              w;
        if (reset) begin
            check("rst_grant", grant, 0);
            check("rst_ack", ack, 0);
            check("rst_we", fifo_write_e, 0);
            check("rst_busy", busy, 0);
            check("rst_data", fifo_data_in, 0);
            model_reset();
            return;
        end
        ef = (sb.size() == DEPTH);
        eg = m_busy ? NREQ'(1 << m_last) : '0;
        ew = m_busy && req[m_last] && !ef;
        ea = ew ? eg : '0;
        ed = ew ? din[int'(m_last)*DW +: DW] : '0;
        check("full", fifo_full, ef);
        check("empty", fifo_empty, sb.size() == 0);
        check("grant", grant, eg);
        check("ack", ack, ea);
        check("write_e", fifo_write_e, ew);
        check("data_in", fifo_data_in, ed);
        check("busy", busy, m_busy);
        check("oh_grant", $onehot0(grant), 1);
        check("oh_ack", $onehot0(ack), 1);
        check("ack_in_grant", ack & ~grant, 0);
        check("we_eq_ack", fifo_write_e, |ack);
        check("no_wr_full", fifo_write_e & fifo_full, 0);

        for (int i = 0; i < NREQ; i++) ack_cnt[i] += int'(ack[i]);
        if (grant != 0 && prev_grant == 0) grant_log.push_back(grant);
        prev_grant = grant;

        if (rd_en && sb.size() != 0) begin
            check("rdata", fifo_dout, sb[0]);
            rd_log.push_back(fifo_dout);
            void'(sb.pop_front());
        end
        if (ew) sb.push_back(ed);

        if (!m_busy) begin
            if (req != 0) begin
                for (int off = 1; off <= NREQ; off++) begin
                    w = (int'(m_last) + off) % NREQ;
                    if (req[w]) begin
                        m_last = 2'(w);
                        break;
                    end
                end
                m_cnt  = 0;
                m_busy = 1'b1;
            end
        end else begin
            if (!req[m_last] || (ew && m_cnt == MAX_BURST - 1)) m_busy = 1'b0;
            if (ew) m_cnt++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        step();
        reset = 1'b1;
        req   = '0;
        rd_en = 1'b0;
        step();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_acks(input int idx, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (ack_cnt[idx] >= n) break;
        end
        check("wait_ack", ack_cnt[idx] >= n, 1);
    endtask

    logic [NREQ-1:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [DW-1:0]   exp_rd    [8] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h11, 8'h11, 8'h11, 8'h11};
    int              n40;

    initial begin
        clear_logs();

        // Reset held with every producer requesting: nothing may be granted.
        #5;
        check("t1_grant_a", grant, 0);
        check("t1_we_a", fifo_write_e, 0);
        check("t1_ack_a", ack, 0);
        #5.5;
        check("t1_grant_b", grant, 0);
        check("t1_we_b", fifo_write_e, 0);
        check("t1_ack_b", ack, 0);
        #0.5;
        reset = 1'b0;

        // Sole requester: bursts of 4 with bubbles until the FIFO fills, then stall.
        req         = 4'b0001;
        din[7:0]    = 8'h03;
        repeat (14) step();
        check("t2_acks8", ack_cnt[0], 8);
        check("t2_grant_held", grant, 4'b0001);
        check("t2_full", fifo_full, 1);
        check("t2_we_stall", fifo_write_e, 0);
        check("t2_ack_stall", ack, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        check("t2_acks9", ack_cnt[0], 9);
        repeat (2) step();
        check("t2_acks9_hold", ack_cnt[0], 9);
        check("t2_full_again", fifo_full, 1);
        req   = '0;
        rd_en = 1'b1;
        repeat (12) step();
        check("t2_drained", fifo_empty, 1);

        // All producers requesting: strict rotation 0,1,2,3,0.
        reset_pulse();
        req   = 4'b1111;
        din   = {8'h13, 8'h12, 8'h11, 8'h10};
        rd_en = 1'b1;
        repeat (27) step();
        req = '0;
        repeat (12) step();
        rd_en = 1'b0;
        check("t3_ngrants", grant_log.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check($sformatf("t3_order%0d", i), grant_log[i], exp_order[i]);
        end
        check("t3_nreads", rd_log.size() >= 8, 1);
        for (int i = 0; i < 8; i++) begin
            if (i < rd_log.size()) check($sformatf("t3_rd%0d", i), rd_log[i], exp_rd[i]);
        end

        // Owner drops its request after two words; producer 2 takes over.
        reset_pulse();
        req       = 4'b0101;
        din       = '0;
        din[7:0]  = 8'h40;
        din[23:16] = 8'h42;
        rd_en     = 1'b1;
        wait_acks(0, 2, 20);
        req = 4'b0100;
        repeat (12) step();
        req = '0;
        repeat (6) step();
        rd_en = 1'b0;
        check("t4_owner0_words", ack_cnt[0], 2);
        check("t4_ngrants", grant_log.size() >= 2, 1);
        if (grant_log.size() >= 2) begin
            check("t4_grant0", grant_log[0], 4'b0001);
            check("t4_grant1", grant_log[1], 4'b0100);
        end
        n40 = 0;
        foreach (rd_log[i]) if (rd_log[i] == 8'h40) n40++;
        check("t4_reads40", n40, 2);

        // Reset in the middle of a burst clears grant/busy asynchronously.
        reset_pulse();
        req      = 4'b0001;
        din[7:0] = 8'h55;
        rd_en    = 1'b1;
        wait_acks(0, 2, 20);
        reset = 1'b1;
        #1;
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        check("t5_we", fifo_write_e, 0);
        check("t5_ack", ack, 0);
        step();
        reset = 1'b0;
        req   = 4'b0011;
        clear_logs();
        repeat (4) step();
        check("t5_ngrants", grant_log.size() >= 1, 1);
        if (grant_log.size() >= 1) check("t5_first", grant_log[0], 4'b0001);
        req = '0;
        repeat (12) step();
        check("t5_drained", fifo_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sfifo_wr_arb
